// File: rtl/uart_cmd_pkg.sv
// Shared types for the UART command transmitter: command kinds, opcode bytes,
// FSM states, and helpers that map a captured command onto its byte sequence.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    RF_WR   = 2'd0,
    RF_RD   = 2'd1,
    ALU_OP  = 2'd2,
    ALU_NOP = 2'd3
  } cmd_type_e;

  localparam logic [7:0] OP_RF_WR   = 8'hAA;
  localparam logic [7:0] OP_RF_RD   = 8'hBB;
  localparam logic [7:0] OP_ALU_OP  = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP
  } state_e;

  // Index of the final byte of a command; the byte counter stops here.
  function automatic logic [1:0] cmd_last_idx(cmd_type_e t);
    case (t)
      RF_WR:   return 2'd2;
      ALU_OP:  return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [7:0] cmd_byte(cmd_type_e t, logic [3:0] addr,
                                          logic [7:0] d0, logic [7:0] d1,
                                          logic [1:0] idx);
    logic [7:0] a8;
    a8 = {4'h0, addr};
    case (t)
      RF_WR: begin
        case (idx)
          2'd0:    return OP_RF_WR;
          2'd1:    return a8;
          default: return d0;
        endcase
      end
      RF_RD:   return (idx == 2'd0) ? OP_RF_RD : a8;
      ALU_OP: begin
        case (idx)
          2'd0:    return OP_ALU_OP;
          2'd1:    return d0;
          2'd2:    return d1;
          default: return a8;
        endcase
      end
      default: return (idx == 2'd0) ? OP_ALU_NOP : a8;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_tx_if.sv
// Command handshake bundle between a requester (master) and uart_cmd_tx (slave).
interface uart_cmd_tx_if;
  logic                   cmd_valid;
  logic                   cmd_ready;
  uart_cmd_pkg::cmd_type_e cmd_type;
  logic [3:0]             cmd_addr;
  logic [7:0]             cmd_data0;
  logic [7:0]             cmd_data1;

  modport master (output cmd_valid, cmd_type, cmd_addr, cmd_data0, cmd_data1,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_type, cmd_addr, cmd_data0, cmd_data1,
                  output cmd_ready);
endinterface

// File: rtl/uart_byte_ser.sv
// Per-byte bit timer and data/parity source; the caller's FSM decides which
// bit is on the line and asks for the next data bit via shift.
module uart_byte_ser #(
  parameter int CLKS_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              load,
  input  logic              shift,
  input  logic [7:0]        byte_in,
  input  logic [CLKS_W-1:0] period,
  input  logic              par_type,
  output logic              bit_data,
  output logic              par_bit,
  output logic              bit_done,
  output logic              last_bit
);

  logic [CLKS_W-1:0] cnt;
  logic [7:0]        byte_q;
  logic [2:0]        sel;

  // period is never zero here; the owner clamps it to at least one cycle.
  assign bit_done = run && (cnt == period - CLKS_W'(1));
  assign bit_data = byte_q[sel];
  assign last_bit = (sel == 3'd7);
  assign par_bit  = (^byte_q) ^ par_type;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      byte_q <= '0;
      sel    <= '0;
    end else if (load) begin
      cnt    <= '0;
      byte_q <= byte_in;
      sel    <= '0;
    end else begin
      if (run)   cnt <= bit_done ? '0 : cnt + CLKS_W'(1);
      if (shift) sel <= sel + 3'd1;
    end
  end

endmodule

// File: rtl/uart_cmd_tx.sv
// UART command transmitter: captures a command, sends its opcode/operand bytes
// as framed serial characters. Define CMD_TX_INTER_BYTE_GAP_EN for an idle bit between bytes.
module uart_cmd_tx
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  uart_cmd_tx_if.slave      cmd,
  input  logic [CLKS_W-1:0] clks_per_bit,
  input  logic              par_en,
  input  logic              par_type,
  output logic              tx_o,
  output logic              busy,
  output logic              done
);

  state_e            state, state_next;
  logic [1:0]        byte_idx, byte_idx_next;
  cmd_type_e         type_q;
  logic [3:0]        addr_q;
  logic [7:0]        d0_q, d1_q;
  logic              par_en_q, par_type_q;
  logic [CLKS_W-1:0] period_q;

  logic       accept, load, shift, done_next, last_byte;
  logic [7:0] load_byte;
  logic       ser_bit, par_bit, bit_done, last_bit;

  assign cmd.cmd_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign accept        = cmd.cmd_valid && (state == IDLE);
  assign last_byte     = (byte_idx == cmd_last_idx(type_q));

  uart_byte_ser #(.CLKS_W(CLKS_W)) u_ser (
    .clk      (CLK),
    .rst      (RST),
    .run      (busy),
    .load     (load),
    .shift    (shift),
    .byte_in  (load_byte),
    .period   (period_q),
    .par_type (par_type_q),
    .bit_data (ser_bit),
    .par_bit  (par_bit),
    .bit_done (bit_done),
    .last_bit (last_bit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      byte_idx   <= '0;
      done       <= 1'b0;
      type_q     <= RF_WR;
      addr_q     <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      period_q   <= CLKS_W'(1);
    end else begin
      state    <= state_next;
      byte_idx <= byte_idx_next;
      done     <= done_next;
      if (accept) begin
        type_q     <= cmd.cmd_type;
        addr_q     <= cmd.cmd_addr;
        d0_q       <= cmd.cmd_data0;
        d1_q       <= cmd.cmd_data1;
        par_en_q   <= par_en;
        par_type_q <= par_type;
        period_q   <= (clks_per_bit == '0) ? CLKS_W'(1) : clks_per_bit;
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next    = state;
    byte_idx_next = byte_idx;
    load          = 1'b0;
    shift         = 1'b0;
    done_next     = 1'b0;
    load_byte     = cmd_byte(type_q, addr_q, d0_q, d1_q, byte_idx + 2'd1);
    case (state)
      IDLE: begin
        // The first byte is built from live inputs; they are captured on this same edge.
        if (accept) begin
          state_next    = START;
          load          = 1'b1;
          byte_idx_next = '0;
          load_byte     = cmd_byte(cmd.cmd_type, cmd.cmd_addr, cmd.cmd_data0,
                                   cmd.cmd_data1, 2'd0);
        end
      end
      START:  if (bit_done) state_next = DATA;
      DATA: begin
        if (bit_done) begin
          if (last_bit) state_next = par_en_q ? PARITY : STOP;
          else          shift      = 1'b1;
        end
      end
      PARITY: if (bit_done) state_next = STOP;
      STOP: begin
        if (bit_done) begin
          if (last_byte) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
`ifdef CMD_TX_INTER_BYTE_GAP_EN
            state_next = GAP;
`else
            state_next    = START;
            load          = 1'b1;
            byte_idx_next = byte_idx + 2'd1;
`endif
          end
        end
      end
      GAP: begin
        if (bit_done) begin
          state_next    = START;
          load          = 1'b1;
          byte_idx_next = byte_idx + 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_o = 1'b1;
    case (state)
      START:   tx_o = 1'b0;
      DATA:    tx_o = ser_bit;
      PARITY:  tx_o = par_bit;
      default: tx_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Directed self-checking bench for uart_cmd_tx; decodes tx_o frame by frame
// against hand-computed byte/parity vectors (gap-aware when CMD_TX_INTER_BYTE_GAP_EN is set).
module tb_uart_cmd_tx;
  import uart_cmd_pkg::*;

  localparam int CLKS_W = 6;
`ifdef CMD_TX_INTER_BYTE_GAP_EN
  localparam int GAP_MUL = 1;
`else
  localparam int GAP_MUL = 0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic [CLKS_W-1:0] clks_per_bit;
  logic              par_en, par_type;
  logic              tx_o, busy, done;
  int                n_checks = 0;
  int                n_fail   = 0;
  int                cyc      = 0;
  int                el;

  uart_cmd_tx_if cmd_if ();

  uart_cmd_tx #(.CLKS_W(CLKS_W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .cmd          (cmd_if),
    .clks_per_bit (clks_per_bit),
    .par_en       (par_en),
    .par_type     (par_type),
    .tx_o         (tx_o),
    .busy         (busy),
    .done         (done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive at a negedge; returns at the negedge of the first start-bit cycle.
  task automatic send_cmd(input cmd_type_e t, input logic [3:0] addr,
                          input logic [7:0] d0, input logic [7:0] d1, input int cpb,
                          input logic pe, input logic pt, input bit keep_valid);
    cmd_if.cmd_type  = t;
    cmd_if.cmd_addr  = addr;
    cmd_if.cmd_data0 = d0;
    cmd_if.cmd_data1 = d1;
    clks_per_bit     = CLKS_W'(cpb);
    par_en           = pe;
    par_type         = pt;
    cmd_if.cmd_valid = 1'b1;
    check("accept.ready", cmd_if.cmd_ready, 1);
    @(negedge CLK);
    if (!keep_valid) begin
      // Scramble everything after accept; the frame must use captured values.
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_type  = cmd_type_e'(~t);
      cmd_if.cmd_addr  = ~addr;
      cmd_if.cmd_data0 = ~d0;
      cmd_if.cmd_data1 = ~d1;
      clks_per_bit     = ~CLKS_W'(cpb);
      par_en           = ~pe;
      par_type         = ~pt;
    end
  endtask

  task automatic wait_start(input string tag, input int exp_gap);
    int n = 0;
    while (tx_o === 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check(tag, n, exp_gap);
  endtask

  task automatic rx_byte(input string tag, input logic [7:0] exp_byte, input logic exp_par,
                         input int cpb, input logic pe);
    int          nb;
    logic [10:0] fr;
    logic        unstable, first;
    nb       = pe ? 11 : 10;
    fr       = '0;
    unstable = 1'b0;
    check({tag, ".busy"}, busy, 1);
    for (int b = 0; b < nb; b++) begin
      first = tx_o;
      fr[b] = first;
      for (int c = 0; c < cpb; c++) begin
        if (tx_o !== first) unstable = 1'b1;
        @(negedge CLK);
      end
    end
    check({tag, ".start"}, fr[0], 0);
    check({tag, ".data"}, fr[8:1], exp_byte);
    if (pe) check({tag, ".par"}, fr[9], exp_par);
    check({tag, ".stop"}, fr[nb-1], 1);
    check({tag, ".stable"}, unstable, 0);
  endtask

  task automatic rx_cmd(input string tag, input int n, input logic [31:0] bytes,
                        input logic [3:0] pars, input int cpb, input logic pe,
                        output int elapsed);
    int t0 = 0;
    for (int i = 0; i < n; i++) begin
      wait_start($sformatf("%s.gap%0d", tag, i), (i == 0) ? 0 : GAP_MUL * cpb);
      if (i == 0) t0 = cyc;
      rx_byte($sformatf("%s.b%0d", tag, i), bytes[8*i +: 8], pars[i], cpb, pe);
    end
    elapsed = cyc - t0;
    check({tag, ".done"}, done, 1);
    check({tag, ".idle_busy"}, busy, 0);
    check({tag, ".idle_ready"}, cmd_if.cmd_ready, 1);
    @(negedge CLK);
    check({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_done, n_low;
    RST              = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_type  = RF_WR;
    cmd_if.cmd_addr  = '0;
    cmd_if.cmd_data0 = '0;
    cmd_if.cmd_data1 = '0;
    clks_per_bit     = '0;
    par_en           = 1'b0;
    par_type         = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset.tx", tx_o, 1);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.ready", cmd_if.cmd_ready, 1);
    RST = 1'b0;
    @(negedge CLK);

    // RF_WR, 8 clocks/bit, no parity: 30 bits, done 240 cycles after first start cycle
    send_cmd(RF_WR, 4'h5, 8'h3C, 8'h00, 8, 1'b0, 1'b0, 1'b0);
    rx_cmd("rfwr", 3, {8'h00, 8'h3C, 8'h05, 8'hAA}, 4'b0000, 8, 1'b0, el);
    check("rfwr.latency", el, 240 + GAP_MUL * 16);

    // ALU_OP even parity: CC(4 ones)->0, 12(2)->0, 34(3)->1, 02(1)->1
    send_cmd(ALU_OP, 4'h2, 8'h12, 8'h34, 4, 1'b1, 1'b0, 1'b0);
    rx_cmd("aluop", 4, {8'h02, 8'h34, 8'h12, 8'hCC}, 4'b1100, 4, 1'b1, el);
    check("aluop.latency", el, 176 + GAP_MUL * 12);

    // RF_RD odd parity: BB(6 ones)->1, 0F(4)->1
    send_cmd(RF_RD, 4'hF, 8'h00, 8'h00, 3, 1'b1, 1'b1, 1'b0);
    rx_cmd("rfrd", 2, {16'h0000, 8'h0F, 8'hBB}, 4'b0011, 3, 1'b1, el);
    check("rfrd.latency", el, 66 + GAP_MUL * 3);

    // Reset during data bit 3 of the third byte
    send_cmd(RF_WR, 4'h5, 8'h3C, 8'h00, 4, 1'b0, 1'b0, 1'b0);
    wait_start("rst.gap0", 0);
    rx_byte("rst.b0", 8'hAA, 1'b0, 4, 1'b0);
    wait_start("rst.gap1", GAP_MUL * 4);
    rx_byte("rst.b1", 8'h05, 1'b0, 4, 1'b0);
    wait_start("rst.gap2", GAP_MUL * 4);
    repeat (4 + 3 * 4 + 1) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst.tx", tx_o, 1);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.ready", cmd_if.cmd_ready, 1);
    RST    = 1'b0;
    n_done = 0;
    n_low  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (done === 1'b1) n_done++;
      if (tx_o !== 1'b1) n_low++;
    end
    check("rst.no_done", n_done, 0);
    check("rst.line_idle", n_low, 0);
    send_cmd(ALU_NOP, 4'hF, 8'h00, 8'h00, 2, 1'b0, 1'b0, 1'b0);
    rx_cmd("nop", 2, {16'h0000, 8'h0F, 8'hDD}, 4'b0000, 2, 1'b0, el);
    check("nop.latency", el, 40 + GAP_MUL * 2);

    // clks_per_bit=0 behaves as 1; valid held high, data0 changed while busy
    send_cmd(RF_WR, 4'h3, 8'h55, 8'h00, 0, 1'b0, 1'b0, 1'b1);
    cmd_if.cmd_data0 = 8'hA5;
    check("cpb0.ready_busy", cmd_if.cmd_ready, 0);
    rx_cmd("cpb0a", 3, {8'h00, 8'h55, 8'h03, 8'hAA}, 4'b0000, 1, 1'b0, el);
    check("cpb0a.latency", el, 30 + GAP_MUL * 2);
    cmd_if.cmd_valid = 1'b0;
    rx_cmd("cpb0b", 3, {8'h00, 8'hA5, 8'h03, 8'hAA}, 4'b0000, 1, 1'b0, el);
    check("cpb0b.latency", el, 30 + GAP_MUL * 2);
    repeat (3) @(negedge CLK);
    check("end.busy", busy, 0);
    check("end.tx", tx_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
